// File: rtl/apb_xfer_sched_pkg.sv
// Shared definitions for the APB transfer scheduler: FSM encoding and defaults.
package apb_xfer_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } xfer_state_t;

  localparam int DEFAULT_TIMEOUT = 255;

  // Index width that stays legal for a single-entry vector.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb_xfer_sched_rr_pick.sv
// Combinational round-robin picker: first requester at or after i_ptr wins.
module apb_rr_pick
  import apb_xfer_sched_pkg::*;
#(
  parameter int MASTER_PORTS = 4,
  parameter int IW           = idx_width(MASTER_PORTS)
) (
  input  logic [MASTER_PORTS-1:0] i_reqs,
  input  logic [IW-1:0]           i_ptr,
  output logic [MASTER_PORTS-1:0] o_win,
  output logic [IW-1:0]           o_idx,
  output logic                    o_any
);

  always_comb begin
    o_any = 1'b0;
    o_idx = '0;
    for (int k = 0; k < MASTER_PORTS; k++) begin
      if (!o_any && i_reqs[(int'(i_ptr) + k) % MASTER_PORTS]) begin
        o_any = 1'b1;
        o_idx = IW'((int'(i_ptr) + k) % MASTER_PORTS);
      end
    end
  end

  for (genvar gi = 0; gi < MASTER_PORTS; gi++) begin : g_win
    assign o_win[gi] = o_any && (o_idx == IW'(gi));
  end

endmodule

// File: rtl/apb_xfer_sched.sv
// Shares one downstream APB master port among several requesters: round-robin
// grant, regenerated SETUP/ACCESS phases, and a wait-state watchdog.
module apb_xfer_sched
  import apb_xfer_sched_pkg::*;
#(
  parameter int MASTER_PORTS = 4,
  parameter int BUS_WIDTH    = 16,
  parameter int DATA_WIDTH   = 16,
  parameter int TIMEOUT      = DEFAULT_TIMEOUT
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [MASTER_PORTS*BUS_WIDTH-1:0]  S_PADDR,
  input  logic [MASTER_PORTS-1:0]            S_PWRITE,
  input  logic [MASTER_PORTS-1:0]            S_PSELx,
  input  logic [MASTER_PORTS*DATA_WIDTH-1:0] S_PWDATA,
  output logic [MASTER_PORTS*DATA_WIDTH-1:0] S_PRDATA,
  output logic [MASTER_PORTS-1:0]            S_PREADY,
  output logic [MASTER_PORTS-1:0]            S_PSLVERR,
  output logic [BUS_WIDTH-1:0]               M_PADDR,
  output logic                               M_PWRITE,
  output logic                               M_PSEL,
  output logic                               M_PENABLE,
  output logic [DATA_WIDTH-1:0]              M_PWDATA,
  input  logic [DATA_WIDTH-1:0]              M_PRDATA,
  input  logic                               M_PREADY,
  output logic [MASTER_PORTS-1:0]            grants
);

  localparam int IW = idx_width(MASTER_PORTS);
  localparam int CW = $clog2(TIMEOUT + 1);

  xfer_state_t             r_state, w_state_next;
  logic [IW-1:0]           r_ptr, r_gidx;
  logic [CW-1:0]           r_wait;
  logic [MASTER_PORTS-1:0] r_grants;
  logic [BUS_WIDTH-1:0]    r_paddr;
  logic [DATA_WIDTH-1:0]   r_pwdata;
  logic                    r_pwrite;

  logic [MASTER_PORTS-1:0] w_win;
  logic [IW-1:0]           w_idx;
  logic                    w_any;
  logic                    w_in_access, w_timeout, w_done, w_err;

  apb_rr_pick #(.MASTER_PORTS(MASTER_PORTS), .IW(IW)) u_pick (
    .i_reqs (S_PSELx),
    .i_ptr  (r_ptr),
    .o_win  (w_win),
    .o_idx  (w_idx),
    .o_any  (w_any)
  );

  // Gating with reset keeps the completion strobes quiet while reset is held.
  assign w_in_access = reset && (r_state == ST_ACCESS);
  assign w_timeout   = (r_wait == CW'(TIMEOUT - 1));
  assign w_done      = w_in_access && (M_PREADY || w_timeout);
  assign w_err       = w_in_access && !M_PREADY && w_timeout;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_any) w_state_next = ST_SETUP;
      ST_SETUP:  w_state_next = ST_ACCESS;
      ST_ACCESS: if (M_PREADY || w_timeout) w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ptr    <= '0;
      r_gidx   <= '0;
      r_wait   <= '0;
      r_grants <= '0;
      r_paddr  <= '0;
      r_pwdata <= '0;
      r_pwrite <= 1'b0;
    end else begin
      if (r_state == ST_IDLE && w_any) begin
        r_paddr  <= S_PADDR[w_idx*BUS_WIDTH +: BUS_WIDTH];
        r_pwdata <= S_PWDATA[w_idx*DATA_WIDTH +: DATA_WIDTH];
        r_pwrite <= S_PWRITE[w_idx];
        r_grants <= w_win;
        r_gidx   <= w_idx;
        r_wait   <= '0;
      end
      if (r_state == ST_ACCESS) begin
        if (r_wait != {CW{1'b1}}) r_wait <= r_wait + 1'b1;
        // Timed-out masters rotate too, so a hung slave cannot starve others.
        if (M_PREADY || w_timeout) begin
          r_grants <= '0;
          r_ptr    <= (r_gidx == IW'(MASTER_PORTS - 1)) ? '0 : r_gidx + 1'b1;
        end
      end
    end
  end

  assign M_PADDR   = r_paddr;
  assign M_PWDATA  = r_pwdata;
  assign M_PWRITE  = r_pwrite;
  assign M_PSEL    = (r_state != ST_IDLE);
  assign M_PENABLE = (r_state == ST_ACCESS);
  assign grants    = r_grants;

  for (genvar gi = 0; gi < MASTER_PORTS; gi++) begin : g_resp
    assign S_PREADY[gi]  = w_done && r_grants[gi];
    assign S_PSLVERR[gi] = w_err && r_grants[gi];
    assign S_PRDATA[gi*DATA_WIDTH +: DATA_WIDTH] =
      (w_done && r_grants[gi] && M_PREADY) ? M_PRDATA : '0;
  end

endmodule

// File: tb/tb_apb_xfer_sched.sv
// Directed bench for apb_xfer_sched: scoreboard of expected completions plus
// cycle-accurate phase checks.
module tb_apb_xfer_sched;

  localparam int NM = 4;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int TO = 8;

  logic              clk;
  logic              reset;
  logic [NM*AW-1:0]  S_PADDR;
  logic [NM-1:0]     S_PWRITE;
  logic [NM-1:0]     S_PSELx;
  logic [NM*DW-1:0]  S_PWDATA;
  logic [NM*DW-1:0]  S_PRDATA;
  logic [NM-1:0]     S_PREADY;
  logic [NM-1:0]     S_PSLVERR;
  logic [AW-1:0]     M_PADDR;
  logic              M_PWRITE;
  logic              M_PSEL;
  logic              M_PENABLE;
  logic [DW-1:0]     M_PWDATA;
  logic [DW-1:0]     M_PRDATA;
  logic              M_PREADY;
  logic [NM-1:0]     grants;

  apb_xfer_sched #(
    .MASTER_PORTS(NM), .BUS_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .S_PADDR(S_PADDR), .S_PWRITE(S_PWRITE), .S_PSELx(S_PSELx),
    .S_PWDATA(S_PWDATA), .S_PRDATA(S_PRDATA), .S_PREADY(S_PREADY),
    .S_PSLVERR(S_PSLVERR), .M_PADDR(M_PADDR), .M_PWRITE(M_PWRITE),
    .M_PSEL(M_PSEL), .M_PENABLE(M_PENABLE), .M_PWDATA(M_PWDATA),
    .M_PRDATA(M_PRDATA), .M_PREADY(M_PREADY), .grants(grants)
  );

  typedef struct {
    int          m;
    logic [15:0] data;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  int          n_vec  = 0;
  int          n_miss = 0;
  logic [NM-1:0] keep;
  logic        sl_hang;
  int          sl_waits;
  int          sl_cnt;
  logic [15:0] sl_base;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  // Slave model: ready after sl_waits wait states, read data = base + address.
  initial begin
    M_PREADY = 1'b0;
    M_PRDATA = '0;
    sl_cnt   = 0;
    forever begin
      @(negedge clk);
      if (M_PSEL && M_PENABLE) begin
        M_PREADY = !sl_hang && (sl_cnt == sl_waits);
        M_PRDATA = M_PWRITE ? 16'h0000 : sl_base + M_PADDR;
        sl_cnt++;
      end else begin
        M_PREADY = 1'b0;
        M_PRDATA = 16'hDEAD;
        sl_cnt   = 0;
      end
    end
  end

  // Masters drop their request once served unless asked to keep it.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      for (int m = 0; m < NM; m++)
        if (S_PREADY[m] && !keep[m]) S_PSELx[m] = 1'b0;
    end
  end

  // Monitor: every completion strobe must match the head of the scoreboard.
  initial begin
    exp_t          e;
    logic [NM-1:0] mask;
    logic [63:0]   want_d;
    forever begin
      @(negedge clk);
      #1;
      if (S_PREADY != '0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pready", 64'(S_PREADY), 64'd0);
        end else begin
          e = exp_q.pop_front();
          mask = '0;
          mask[e.m] = 1'b1;
          want_d = 64'(e.data) << (e.m * DW);
          $display("xfer master=%0d pready=%b pslverr=%b prdata=%h", e.m, S_PREADY, S_PSLVERR, S_PRDATA);
          check("sb_pready", 64'(S_PREADY), 64'(mask));
          check("sb_pslverr", 64'(S_PSLVERR), e.err ? 64'(mask) : 64'd0);
          check("sb_prdata", S_PRDATA, want_d);
        end
      end
    end
  end

  task automatic issue(input int m, input logic [15:0] a, input logic [15:0] wd,
                       input logic w, input logic [15:0] exp_d, input logic exp_err,
                       input bit push);
    exp_t e;
    S_PADDR[m*AW +: AW]  = a;
    S_PWDATA[m*DW +: DW] = wd;
    S_PWRITE[m]          = w;
    S_PSELx[m]           = 1'b1;
    e.m = m; e.data = exp_d; e.err = exp_err;
    if (push) exp_q.push_back(e);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_grants"}, 64'(grants), 64'd0);
    check({tag, "_psel"}, 64'(M_PSEL), 64'd0);
    check({tag, "_penable"}, 64'(M_PENABLE), 64'd0);
    check({tag, "_paddr"}, 64'(M_PADDR), 64'd0);
    check({tag, "_pwdata"}, 64'(M_PWDATA), 64'd0);
    check({tag, "_pwrite"}, 64'(M_PWRITE), 64'd0);
    check({tag, "_pready"}, 64'(S_PREADY), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #3;
    reset = 1'b0;
    S_PSELx = '0;
    keep = '0;
    sl_hang = 1'b0;
    sl_waits = 0;
    @(negedge clk);
    #1;
    check_reset_outputs("rst");
    @(negedge clk);
    #3;
    reset = 1'b1;
  endtask

  // Called in the request cycle; ends at the idle bubble after completion.
  task automatic run_xfer(input int m, input int n_access, input bit drop);
    logic [NM-1:0] g;
    g = '0;
    g[m] = 1'b1;
    @(negedge clk); #1;
    check("setup_grants", 64'(grants), 64'(g));
    check("setup_psel", 64'(M_PSEL), 64'd1);
    check("setup_penable", 64'(M_PENABLE), 64'd0);
    if (drop) begin
      S_PSELx = '0;
      keep = '0;
    end
    for (int i = 0; i < n_access; i++) begin
      @(negedge clk); #1;
      check("access_penable", 64'(M_PENABLE), 64'd1);
      check("access_pready", 64'(S_PREADY[m]), (i == n_access - 1) ? 64'd1 : 64'd0);
    end
    @(negedge clk); #1;
    check("idle_psel", 64'(M_PSEL), 64'd0);
    check("idle_grants", 64'(grants), 64'd0);
  endtask

  initial begin
    reset    = 1'b0;
    S_PADDR  = '0;
    S_PWRITE = '0;
    S_PSELx  = '0;
    S_PWDATA = '0;
    keep     = '0;
    sl_hang  = 1'b0;
    sl_waits = 0;
    sl_base  = 16'h0000;

    // Single write from master 0, zero-wait slave
    do_reset();
    issue(0, 16'h0040, 16'hBEEF, 1'b1, 16'h0000, 1'b0, 1'b1);
    @(negedge clk); #1;
    check("w_paddr", 64'(M_PADDR), 64'h0040);
    check("w_pwdata", 64'(M_PWDATA), 64'hBEEF);
    check("w_pwrite", 64'(M_PWRITE), 64'd1);
    check("w_grants", 64'(grants), 64'b0001);
    check("w_penable", 64'(M_PENABLE), 64'd0);
    @(negedge clk); #1;
    check("w_access_penable", 64'(M_PENABLE), 64'd1);
    check("w_pready_t2", 64'(S_PREADY), 64'b0001);
    @(negedge clk); #1;
    check("w_idle_psel", 64'(M_PSEL), 64'd0);
    check("w_hold_paddr", 64'(M_PADDR), 64'h0040);

    // Four simultaneous reads served in rotation, 3 cycles apart
    do_reset();
    sl_base = 16'h1000;
    for (int m = 0; m < NM; m++)
      issue(m, 16'(m), 16'h0000, 1'b0, 16'h1000 + 16'(m), 1'b0, 1'b1);
    for (int m = 0; m < NM; m++) run_xfer(m, 1, 1'b0);

    // Three wait states on a read of 0x5A5A
    do_reset();
    sl_base = 16'h5A5A;
    sl_waits = 3;
    issue(2, 16'h0000, 16'h0000, 1'b0, 16'h5A5A, 1'b0, 1'b1);
    run_xfer(2, 4, 1'b0);

    // Watchdog: slave never ready
    do_reset();
    sl_hang = 1'b1;
    issue(3, 16'h0007, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1);
    run_xfer(3, TO, 1'b0);
    sl_hang = 1'b0;

    // Slave ready in the last allowed cycle wins over the watchdog
    do_reset();
    sl_base = 16'h1000;
    sl_waits = TO - 1;
    issue(1, 16'h0003, 16'h0000, 1'b0, 16'h1003, 1'b0, 1'b1);
    run_xfer(1, TO, 1'b0);

    // Reset during ACCESS abandons the transfer and rewinds the pointer
    do_reset();
    sl_base = 16'h1000;
    issue(1, 16'h0001, 16'h0000, 1'b0, 16'h1001, 1'b0, 1'b1);
    run_xfer(1, 1, 1'b0);
    #2;
    sl_hang = 1'b1;
    issue(0, 16'h0000, 16'h0000, 1'b0, 16'h1000, 1'b0, 1'b0);
    issue(2, 16'h0002, 16'h0000, 1'b0, 16'h1002, 1'b0, 1'b0);
    @(negedge clk); #1;
    check("rot_grants_m2", 64'(grants), 64'b0100);
    @(negedge clk); #3;
    reset = 1'b0;
    @(negedge clk); #1;
    check_reset_outputs("midrst");
    sl_hang = 1'b0;
    issue(0, 16'h0000, 16'h0000, 1'b0, 16'h1000, 1'b0, 1'b1);
    issue(2, 16'h0002, 16'h0000, 1'b0, 16'h1002, 1'b0, 1'b1);
    @(negedge clk); #3;
    reset = 1'b1;
    run_xfer(0, 1, 1'b0);
    run_xfer(2, 1, 1'b0);

    // Continuous master 1 against master 2: grants alternate
    do_reset();
    sl_base = 16'h1000;
    keep = 4'b0110;
    issue(1, 16'h0001, 16'h0000, 1'b0, 16'h1001, 1'b0, 1'b1);
    issue(2, 16'h0002, 16'h0000, 1'b0, 16'h1002, 1'b0, 1'b1);
    exp_q.push_back('{m: 1, data: 16'h1001, err: 1'b0});
    exp_q.push_back('{m: 2, data: 16'h1002, err: 1'b0});
    run_xfer(1, 1, 1'b0);
    run_xfer(2, 1, 1'b0);
    run_xfer(1, 1, 1'b0);
    run_xfer(2, 1, 1'b1);

    repeat (3) @(negedge clk);
    #1;
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
